// File: rtl/systolic_array_os_nxn.sv
// Output-stationary N x N systolic matrix multiplier, C = A(NxK) x B(KxN), with a
// start/busy/done handshake and an optional accumulate-across-passes mode.
module systolic_array_os_nxn #(
  parameter int unsigned N  = 2,
  parameter int unsigned K  = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2 * DW + $clog2(K) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                acc_keep,
  input  logic [N*K*DW-1:0]   a_flat,
  input  logic [K*N*DW-1:0]   b_flat,
  output logic                busy,
  output logic                done,
  output logic [N*N*AW-1:0]   c_flat
);

  localparam int unsigned RunLen = K + 2 * N - 2;
  localparam int unsigned TW     = (RunLen > 1) ? $clog2(RunLen) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e              state_q;
  logic [TW-1:0]       t_q;
  logic                keep_q;
  logic [N*K*DW-1:0]   a_q;
  logic [K*N*DW-1:0]   b_q;
  logic [N*N*AW-1:0]   acc_flat;

  logic [DW-1:0] a_feed [N];
  logic [DW-1:0] b_feed [N];
  logic [DW-1:0] a_pipe [N][N];
  logic [DW-1:0] b_pipe [N][N];

  // done and busy are registered, so done rises on the edge that leaves StDone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      keep_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      c_flat  <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            keep_q  <= acc_keep;
            busy    <= 1'b1;
          end
        end
        StLoad: begin
          a_q     <= a_flat;
          b_q     <= b_flat;
          t_q     <= '0;
          state_q <= StRun;
        end
        StRun: begin
          if (t_q == TW'(RunLen - 1)) begin
            state_q <= StDone;
            busy    <= 1'b0;
          end else begin
            t_q <= t_q + TW'(1);
          end
        end
        StDone: begin
          c_flat  <= acc_flat;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Edge feeders: row i is skewed by i cycles, column j by j cycles.
  for (genvar i = 0; i < N; i++) begin : g_feed
    logic [DW-1:0] a_val;
    logic [DW-1:0] b_val;
    always_comb begin
      a_val = '0;
      b_val = '0;
      if (state_q == StRun) begin
        for (int k = 0; k < K; k++) begin
          if (t_q == TW'(i + k)) begin
            a_val = a_q[(i*K+k)*DW +: DW];
            b_val = b_q[(k*N+i)*DW +: DW];
          end
        end
      end
    end
    assign a_feed[i] = a_val;
    assign b_feed[i] = b_val;
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic [DW-1:0]   a_in;
      logic [DW-1:0]   b_in;
      logic [DW-1:0]   a_r;
      logic [DW-1:0]   b_r;
      logic [AW-1:0]   acc_r;
      logic [2*DW-1:0] prod;

      if (j == 0) begin : g_a_edge
        assign a_in = a_feed[i];
      end else begin : g_a_hop
        assign a_in = a_pipe[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_feed[j];
      end else begin : g_b_hop
        assign b_in = b_pipe[i-1][j];
      end

      assign prod = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_r   <= '0;
          b_r   <= '0;
          acc_r <= '0;
        end else if (state_q == StLoad) begin
          a_r <= '0;
          b_r <= '0;
          if (!keep_q) acc_r <= '0;
        end else if (state_q == StRun) begin
          acc_r <= acc_r + AW'(prod);
          a_r   <= a_in;
          b_r   <= b_in;
        end
      end

      assign a_pipe[i][j]                 = a_r;
      assign b_pipe[i][j]                 = b_r;
      assign acc_flat[(i*N+j)*AW +: AW]   = acc_r;
    end
  end

endmodule

// File: tb/tb_systolic_array_os_nxn.sv
// Bench for systolic_array_os_nxn: a 2x2 (K=3) instance driven from a vector table and
// a 4x4 (K=4) instance checked against a matrix-multiply reference model.
module tb_systolic_array_os_nxn;

  localparam int N   = 2;
  localparam int K   = 3;
  localparam int DW  = 8;
  localparam int AW  = 2 * DW + $clog2(K) + 1;
  localparam int N4  = 4;
  localparam int K4  = 4;
  localparam int AW4 = 2 * DW + $clog2(K4) + 1;

  logic clk;
  logic rst;

  logic                start_s, keep_s, busy_s, done_s;
  logic [N*K*DW-1:0]   a_s;
  logic [K*N*DW-1:0]   b_s;
  logic [N*N*AW-1:0]   c_s;

  logic                start_b, keep_b, busy_b, done_b;
  logic [N4*K4*DW-1:0] a_b;
  logic [K4*N4*DW-1:0] b_b;
  logic [N4*N4*AW4-1:0] c_b;

  systolic_array_os_nxn #(.N(N), .K(K), .DW(DW)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .acc_keep(keep_s), .a_flat(a_s), .b_flat(b_s),
    .busy(busy_s), .done(done_s), .c_flat(c_s)
  );

  systolic_array_os_nxn #(.N(N4), .K(K4), .DW(DW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .acc_keep(keep_b), .a_flat(a_b), .b_flat(b_b),
    .busy(busy_b), .done(done_b), .c_flat(c_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N*K*DW-1:0] a;
    logic [K*N*DW-1:0] b;
    logic              keep;
    logic [N*N*AW-1:0] c;
  } vec_t;

  int checks;
  int failures;
  logic [N*N*AW-1:0]   exp_q [$];
  logic [N4*N4*AW4-1:0] exp_b_q [$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [N*K*DW-1:0] pack_op(input int v[N*K]);
    logic [N*K*DW-1:0] r;
    r = '0;
    for (int e = 0; e < N * K; e++) r[e*DW +: DW] = DW'(v[e]);
    return r;
  endfunction

  function automatic logic [N*N*AW-1:0] pack_c(input int v[N*N]);
    logic [N*N*AW-1:0] r;
    r = '0;
    for (int e = 0; e < N * N; e++) r[e*AW +: AW] = AW'(v[e]);
    return r;
  endfunction

  function automatic logic [N4*N4*AW4-1:0] model4(input logic [N4*K4*DW-1:0] a,
                                                 input logic [K4*N4*DW-1:0] b);
    logic [N4*N4*AW4-1:0] r;
    logic [AW4-1:0] s, x, y;
    r = '0;
    for (int i = 0; i < N4; i++) begin
      for (int j = 0; j < N4; j++) begin
        s = '0;
        for (int k = 0; k < K4; k++) begin
          x = AW4'(a[(i*K4+k)*DW +: DW]);
          y = AW4'(b[(k*N4+j)*DW +: DW]);
          s = s + x * y;
        end
        r[(i*N4+j)*AW4 +: AW4] = s;
      end
    end
    return r;
  endfunction

  // One pass on the 2x2 instance; optionally holds start high for the whole pass.
  task automatic run_small(input vec_t v, input bit hold_start);
    logic [N*N*AW-1:0] prev, req;
    int lat, busy_cnt;
    bit stable;
    exp_q.push_back(v.c);
    @(negedge clk);
    a_s = v.a; b_s = v.b; keep_s = v.keep; start_s = 1'b1;
    prev = c_s;
    @(negedge clk);
    if (!hold_start) start_s = 1'b0;
    lat = 0; busy_cnt = 0; stable = 1'b1;
    while (!done_s && lat < 100) begin
      if (busy_s) busy_cnt++;
      if (c_s !== prev) stable = 1'b0;
      @(negedge clk);
      lat++;
      // Operands were latched at LOAD; scramble inputs to prove they are not re-read.
      if (lat == 1) begin
        a_s = {$urandom, $urandom};
        b_s = {$urandom, $urandom};
      end
    end
    start_s = 1'b0;
    check("done_seen", done_s, 1);
    check("latency", lat, 7);
    check("busy_cycles", busy_cnt, 6);
    check("c_stable_during_pass", stable, 1);
    req = exp_q.pop_front();
    check("c_result", c_s, req);
    @(negedge clk);
    check("done_pulse_one_cycle", done_s, 0);
    check("no_restart", busy_s, 0);
    check("c_held", c_s, req);
  endtask

  task automatic run_big(input logic [N4*K4*DW-1:0] a, input logic [K4*N4*DW-1:0] b);
    logic [N4*N4*AW4-1:0] req;
    int lat, busy_cnt;
    exp_b_q.push_back(model4(a, b));
    @(negedge clk);
    a_b = a; b_b = b; keep_b = 1'b0; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done_b && lat < 100) begin
      if (busy_b) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check("big_done_seen", done_b, 1);
    check("big_latency", lat, 12);
    check("big_busy_cycles", busy_cnt, 11);
    req = exp_b_q.pop_front();
    check("big_c_result", c_b, req);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    logic [N*K*DW-1:0] a1, b1, a255;
    logic [N4*K4*DW-1:0] ai, ar;
    logic [K4*N4*DW-1:0] br;
    int dn;

    checks = 0; failures = 0;
    a1   = pack_op('{1, 2, 3, 4, 5, 6});
    b1   = pack_op('{1, 0, 0, 1, 1, 1});
    a255 = pack_op('{default: 255});

    vecs[0] = '{a: a1,   b: b1,   keep: 1'b1, c: pack_c('{4, 5, 10, 11})};
    vecs[1] = '{a: a255, b: a255, keep: 1'b0, c: pack_c('{default: 195075})};
    vecs[2] = '{a: a1,   b: b1,   keep: 1'b0, c: pack_c('{4, 5, 10, 11})};
    vecs[3] = '{a: a1,   b: b1,   keep: 1'b1, c: pack_c('{8, 10, 20, 22})};
    vecs[4] = '{a: a1,   b: b1,   keep: 1'b0, c: pack_c('{4, 5, 10, 11})};

    rst = 1'b1;
    start_s = 1'b0; keep_s = 1'b0; a_s = '0; b_s = '0;
    start_b = 1'b0; keep_b = 1'b0; a_b = '0; b_b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy_s, 0);
    check("reset_done", done_s, 0);
    check("reset_c", c_s, 0);
    check("big_reset_busy", busy_b, 0);
    check("big_reset_c", c_b, 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) run_small(vecs[v], 1'b0);

    // start held high through a whole pass must yield a single accepted pass.
    run_small(vecs[4], 1'b1);

    // Abort mid-RUN (t=2) with reset, then a first pass with acc_keep=1 adds to zero.
    @(negedge clk);
    a_s = a1; b_s = b1; keep_s = 1'b0; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", busy_s, 0);
    check("abort_done", done_s, 0);
    check("abort_c", c_s, 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_s) dn++;
    end
    check("abort_no_done", dn, 0);
    run_small(vecs[0], 1'b0);

    ai = '0;
    for (int i = 0; i < N4; i++) ai[(i*K4+i)*DW +: DW] = 8'd1;
    for (int e = 0; e < K4 * N4; e++) br[e*DW +: DW] = DW'($urandom_range(0, 255));
    run_big(ai, br);
    for (int i = 0; i < N4; i++)
      for (int j = 0; j < N4; j++)
        check("big_identity_elem", c_b[(i*N4+j)*AW4 +: AW4], AW4'(br[(i*N4+j)*DW +: DW]));
    for (int e = 0; e < N4 * K4; e++) ar[e*DW +: DW] = DW'($urandom_range(0, 255));
    for (int e = 0; e < K4 * N4; e++) br[e*DW +: DW] = DW'($urandom_range(0, 255));
    run_big(ar, br);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
